// File: rtl/program_counter_high.sv
// PCH stage: completes 16-bit PC inc/dec from PCL carry, loads from ADH, fixes up page-crossing branches.
// Next-state latency one clock; page_cross is a pure state decode so the timing generator sees no input paths.
module program_counter_high (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] ADH_in,
  input  logic       ADH_PCH,
  input  logic       PCH_PCH,
  input  logic       PCH_DB,
  input  logic       PCH_ADH,
  input  logic       increment,
  input  logic       decrement,
  input  logic       PCLC,
  input  logic       branch_adj,
  input  logic       branch_sign,
  input  logic       branch_carry,
  output logic [7:0] DB_out,
  output logic [7:0] ADH_out,
  output logic       page_cross,
  output logic       pch_wrap
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FIXUP = 1'b1;

  logic [7:0] pch;
  logic [7:0] pch_nxt;
  logic       state;
  logic       state_nxt;
  logic       fix_dir;
  logic       fix_dir_nxt;
  logic       wrap_nxt;
  logic       inc_req;
  logic       dec_req;

  assign inc_req = PCH_PCH & PCLC & increment & ~decrement;
  assign dec_req = PCH_PCH & PCLC & decrement & ~increment;

  always_comb begin
    pch_nxt     = pch;
    state_nxt   = state;
    fix_dir_nxt = fix_dir;
    wrap_nxt    = 1'b0;
    if (ADH_PCH) begin
      pch_nxt   = ADH_in;
      state_nxt = ST_IDLE;
    end else if (state == ST_FIXUP) begin
      // fixup owns the adjust path for its single cycle; branch_adj is ignored here
      state_nxt = ST_IDLE;
      if (fix_dir) begin
        pch_nxt  = pch - 8'd1;
        wrap_nxt = (pch == 8'h00);
      end else begin
        pch_nxt  = pch + 8'd1;
        wrap_nxt = (pch == 8'hFF);
      end
    end else begin
      if (inc_req) begin
        pch_nxt  = pch + 8'd1;
        wrap_nxt = (pch == 8'hFF);
      end else if (dec_req) begin
        pch_nxt  = pch - 8'd1;
        wrap_nxt = (pch == 8'h00);
      end
      if (branch_adj) begin
        if (~branch_sign & branch_carry) begin
          state_nxt   = ST_FIXUP;
          fix_dir_nxt = 1'b0;
        end else if (branch_sign & ~branch_carry) begin
          state_nxt   = ST_FIXUP;
          fix_dir_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pch      <= 8'h00;
      state    <= ST_IDLE;
      fix_dir  <= 1'b0;
      pch_wrap <= 1'b0;
    end else begin
      pch      <= pch_nxt;
      state    <= state_nxt;
      fix_dir  <= fix_dir_nxt;
      pch_wrap <= wrap_nxt;
    end
  end

  assign page_cross = (state == ST_FIXUP);
  assign DB_out     = PCH_DB  ? pch : 8'h00;
  assign ADH_out    = PCH_ADH ? pch : 8'h00;

endmodule

// File: tb/tb_program_counter_high.sv
// Directed plus randomized bench for program_counter_high against a cycle-level arithmetic model.
module tb_program_counter_high;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] ADH_in;
  logic       ADH_PCH, PCH_PCH, PCH_DB, PCH_ADH;
  logic       increment, decrement, PCLC;
  logic       branch_adj, branch_sign, branch_carry;
  logic [7:0] DB_out, ADH_out;
  logic       page_cross, pch_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: PC high byte, pending fixup step (+1/-1/0), wrap flag
  int m_pch  = 0;
  int m_pend = 0;
  int m_wrap = 0;

  always #5 clk = ~clk;

  program_counter_high dut (
    .clk(clk), .nrst(nrst), .ADH_in(ADH_in), .ADH_PCH(ADH_PCH),
    .PCH_PCH(PCH_PCH), .PCH_DB(PCH_DB), .PCH_ADH(PCH_ADH),
    .increment(increment), .decrement(decrement), .PCLC(PCLC),
    .branch_adj(branch_adj), .branch_sign(branch_sign), .branch_carry(branch_carry),
    .DB_out(DB_out), .ADH_out(ADH_out), .page_cross(page_cross), .pch_wrap(pch_wrap)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int delta;
    int raw;
    delta = 0;
    if (!nrst) begin
      m_pch = 0; m_pend = 0; m_wrap = 0;
    end else if (ADH_PCH) begin
      m_pch = int'(ADH_in); m_pend = 0; m_wrap = 0;
    end else begin
      if (m_pend != 0) begin
        delta  = m_pend;
        m_pend = 0;
      end else begin
        if (PCH_PCH && PCLC && (increment != decrement))
          delta = increment ? 1 : -1;
        if (branch_adj && !branch_sign && branch_carry) m_pend = 1;
        else if (branch_adj && branch_sign && !branch_carry) m_pend = -1;
      end
      raw    = m_pch + delta;
      m_wrap = (raw < 0 || raw > 255) ? 1 : 0;
      m_pch  = (raw + 256) % 256;
    end
  endtask

  task automatic check_outs();
    chk("db_bus",  DB_out,  PCH_DB  ? 8'(m_pch) : 8'h00);
    chk("adh_bus", ADH_out, PCH_ADH ? 8'(m_pch) : 8'h00);
    chk("page_cross", {7'b0, page_cross}, (m_pend != 0) ? 8'h01 : 8'h00);
    chk("pch_wrap",   {7'b0, pch_wrap},   8'(m_wrap));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic idle_ctl();
    ADH_PCH = 0; PCH_PCH = 0; increment = 0; decrement = 0; PCLC = 0;
    branch_adj = 0; branch_sign = 0; branch_carry = 0;
  endtask

  task automatic load(input logic [7:0] v);
    idle_ctl();
    ADH_PCH = 1; ADH_in = v;
    tick();
    ADH_PCH = 0;
  endtask

  task automatic branch(input logic s, input logic c);
    idle_ctl();
    branch_adj = 1; branch_sign = s; branch_carry = c;
    tick();
    idle_ctl();
  endtask

  initial begin
    nrst = 0; ADH_in = 8'h5A; idle_ctl(); ADH_PCH = 1; PCH_DB = 1; PCH_ADH = 1;
    tick(); tick();
    chk("rst_db", DB_out, 8'h00);
    chk("rst_adh", ADH_out, 8'h00);
    chk("rst_pc", {7'b0, page_cross}, 8'h00);
    nrst = 1; PCH_ADH = 0;

    load(8'h12);
    PCH_PCH = 1; increment = 1; PCLC = 1; tick(); idle_ctl();
    chk("inc_12", DB_out, 8'h13);
    PCH_PCH = 1; increment = 1; PCLC = 0; tick(); idle_ctl();
    chk("inc_nocarry", DB_out, 8'h13);

    load(8'hFF);
    PCH_PCH = 1; increment = 1; PCLC = 1; tick(); idle_ctl();
    chk("wrap_up_pch", DB_out, 8'h00);
    chk("wrap_up_flag", {7'b0, pch_wrap}, 8'h01);
    tick();
    chk("wrap_up_once", {7'b0, pch_wrap}, 8'h00);
    load(8'h00);
    chk("load_nowrap", {7'b0, pch_wrap}, 8'h00);
    PCH_PCH = 1; decrement = 1; PCLC = 1; tick(); idle_ctl();
    chk("wrap_dn_pch", DB_out, 8'hFF);
    chk("wrap_dn_flag", {7'b0, pch_wrap}, 8'h01);

    load(8'h20);
    branch(1'b0, 1'b1);
    chk("fwd_pc", {7'b0, page_cross}, 8'h01);
    chk("fwd_hold", DB_out, 8'h20);
    tick();
    chk("fwd_pch", DB_out, 8'h21);
    chk("fwd_pc_end", {7'b0, page_cross}, 8'h00);
    load(8'h20);
    branch(1'b1, 1'b0); tick();
    chk("bwd_pch", DB_out, 8'h1F);
    load(8'h20);
    branch(1'b1, 1'b1);
    chk("nocross_pc", {7'b0, page_cross}, 8'h00);
    tick();
    chk("nocross_pch", DB_out, 8'h20);

    load(8'h00);
    branch(1'b1, 1'b0); tick();
    chk("fix_wrap_pch", DB_out, 8'hFF);
    chk("fix_wrap_flag", {7'b0, pch_wrap}, 8'h01);

    load(8'h20);
    branch(1'b0, 1'b1);
    load(8'h80);
    chk("abort_pch", DB_out, 8'h80);
    chk("abort_pc", {7'b0, page_cross}, 8'h00);
    tick();
    chk("abort_noadj", DB_out, 8'h80);
    PCH_PCH = 1; increment = 1; decrement = 1; PCLC = 1; tick(); idle_ctl();
    chk("incdec_hold", DB_out, 8'h80);

    load(8'h40);
    branch_adj = 1; branch_carry = 1; PCH_PCH = 1; increment = 1; PCLC = 1;
    tick(); idle_ctl();
    chk("acc_first", DB_out, 8'h41);
    tick();
    chk("acc_second", DB_out, 8'h42);

    load(8'h30);
    branch(1'b0, 1'b1);
    nrst = 0; tick(); nrst = 1;
    chk("rst_fix_pc", {7'b0, page_cross}, 8'h00);
    chk("rst_fix_pch", DB_out, 8'h00);

    load(8'hC3);
    PCH_DB = 1; PCH_ADH = 0; #1;
    chk("bus_db", DB_out, 8'hC3);
    chk("bus_adh_off", ADH_out, 8'h00);
    PCH_ADH = 1; #1;
    chk("bus_both_db", DB_out, 8'hC3);
    chk("bus_both_adh", ADH_out, 8'hC3);

    for (int i = 0; i < 3000; i++) begin
      nrst         = ($urandom_range(0, 63) != 0);
      ADH_PCH      = ($urandom_range(0, 9) == 0);
      ADH_in       = 8'($urandom);
      PCH_PCH      = ($urandom_range(0, 3) != 0);
      increment    = 1'($urandom);
      decrement    = 1'($urandom);
      PCLC         = ($urandom_range(0, 2) != 0);
      branch_adj   = ($urandom_range(0, 3) == 0);
      branch_sign  = 1'($urandom);
      branch_carry = 1'($urandom);
      PCH_DB       = 1'($urandom);
      PCH_ADH      = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
